// File: rtl/contador_descendente.sv
// Loadable down-counter / countdown timer: one decrement per PRESCALE clocks, terminal-count pulse.
// Optional macro CONTADOR_AUTO_RELOAD_EN turns terminal count into a reload (periodic tick mode).
module contador_descendente #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             zero_pulse,
   output logic             done,
   output logic [1:0]       dbg_state
);

   localparam int PW = $clog2(PRESCALE) + 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] count_n;
   logic [WIDTH-1:0] reload, reload_n;
   logic [PW-1:0]    presc, presc_n;
   logic             busy_n, zero_n, done_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         count      <= '0;
         reload     <= '0;
         presc      <= '0;
         busy       <= 1'b0;
         zero_pulse <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         reload     <= reload_n;
         presc      <= presc_n;
         busy       <= busy_n;
         zero_pulse <= zero_n;
         done       <= done_n;
      end
   end

   // Priority chain: load > pause > start > prescaler tick.
   always_comb begin
      state_n  = state;
      count_n  = count;
      reload_n = reload;
      presc_n  = presc;
      zero_n   = 1'b0;
      done_n   = done;

      if (load) begin
         count_n  = load_val;
         reload_n = load_val;
         case (state)
            S_RUN, S_PAUSE: begin
               presc_n = '0;
               if (load_val == '0) begin
                  state_n = S_DONE;
                  zero_n  = 1'b1;
                  done_n  = 1'b1;
               end
            end
            S_DONE: begin
               done_n  = 1'b0;
               state_n = S_IDLE;
            end
            default: ;
         endcase
      end else if (pause) begin
         if (state == S_RUN) state_n = S_PAUSE;
      end else if (start && state != S_RUN) begin
         case (state)
            S_IDLE: begin
               if (count != '0) begin
                  state_n = S_RUN;
                  presc_n = '0;
               end else begin
                  state_n = S_DONE;
                  zero_n  = 1'b1;
                  done_n  = 1'b1;
               end
            end
            S_PAUSE: state_n = S_RUN;
            S_DONE: begin
               if (reload != '0) begin
                  count_n = reload;
                  presc_n = '0;
                  done_n  = 1'b0;
                  state_n = S_RUN;
               end else begin
                  zero_n = 1'b1;
               end
            end
            default: ;
         endcase
      end else if (state == S_RUN) begin
         if (presc == PRE_LAST) begin
            presc_n = '0;
            if (count != '0) count_n = count - WIDTH'(1);
            if (count == WIDTH'(1)) begin
               zero_n = 1'b1;
`ifdef CONTADOR_AUTO_RELOAD_EN
               count_n = reload;
`else
               state_n = S_DONE;
               done_n  = 1'b1;
`endif
            end
         end else begin
            presc_n = presc + PW'(1);
         end
      end

      busy_n = (state_n == S_RUN) || (state_n == S_PAUSE);
   end

   assign dbg_state = state;

endmodule
